alarm_bank: RTL
===============

# alarm_bank

Multi-slot alarm controller for the digital alarm clock: holds N independently programmable alarm times and compares them against the running time on each second tick. It runs one ringing/snooze state machine with auto-timeout and a gated beep pattern. It sits between the timekeeping and FSM logic and the buzzer/LED outputs. It replaces the single alarm compare-and-snooze path with a parametrised, N-slot block.

## Interface

Parameters:
- N_ALARMS, 4: number of alarm slots (1–16). IDX_W = max(1, clog2(N_ALARMS)).
- RING_SECS, 60: seconds of continuous ringing before auto-timeout.
- SNOOZE_SECS, 300: snooze duration in seconds.
- MAX_SNOOZE, 3: snooze limit (used only with ALARM_SNOOZE_LIMIT_EN).
- BEEP_HALF, 12000000: clk cycles per beep half-period.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-low reset.
- sec_tick, in, 1: one-cycle pulse once per second.
- cur_hour, in, 5: current hour, binary 0–23.
- cur_min, in, 6: current minute, binary 0–59.
- cur_sec, in, 6: current second, binary 0–59.
- wr_en, in, 1: slot write strobe.
- wr_idx, in, IDX_W: slot to write.
- wr_hour, in, 5: alarm hour to write.
- wr_min, in, 6: alarm minute to write.
- wr_arm, in, 1: slot enable value to write.
- snooze, in, 1: one-cycle debounced pulse.
- dismiss, in, 1: one-cycle debounced pulse.
- alarm_on, out, 1: high in RING or SNOOZE.
- ringing, out, 1: high in RING only.
- buzzy, out, 1: beep pattern, active high.
- active_idx, out, IDX_W: slot that triggered the current episode.
- snooze_cnt, out, 4: snoozes taken this episode (saturating at 15).
- missed, out, 1: one-cycle pulse on ring timeout.

## Operation

- Slot storage: per slot, hour[4:0], min[5:0], armed. A write with wr_en updates all three fields of slot wr_idx on the next clk edge. wr_idx >= N_ALARMS is ignored.
- Match: on a sec_tick cycle, slot k matches when it is armed, cur_sec==0, cur_hour==hour[k] and cur_min==min[k]. When several slots match, the lowest index wins.
- States: IDLE, RING, SNOOZE.
- IDLE → RING: any match. This latches active_idx, clears snooze_cnt, loads the ring timer with RING_SECS and resets the beep counter.
- RING → IDLE on dismiss.
- RING → SNOOZE on snooze. This loads the snooze timer with SNOOZE_SECS and increments snooze_cnt.
- RING → IDLE with a missed pulse when the ring timer reaches 0. The timer decrements on sec_tick.
- SNOOZE → IDLE on dismiss.
- SNOOZE → RING when the snooze timer reaches 0. The timer decrements on sec_tick. The ring timer reloads and the beep counter resets.
- New matches are ignored while in RING or SNOOZE.
- Priority in a single cycle: reset > dismiss > disarm of the active slot > snooze > timer expiry > match.
- Disarming the active slot with wr_en=1, wr_idx==active_idx and wr_arm=0 while in RING or SNOOZE forces IDLE. No missed pulse is generated.
- Any other write during an episode, including retiming the active slot, does not affect the episode.
- Snooze or dismiss in IDLE, and snooze in SNOOZE, are ignored.
- buzzy = ringing & beep_phase. beep_phase is 1 on the first RING cycle and toggles every BEEP_HALF clk cycles while in RING.

## Timing

- All outputs are registered.
- Reset values: alarm_on=0, ringing=0, buzzy=0, active_idx=0, snooze_cnt=0, missed=0, state IDLE. All slots reset to 00:00, disarmed.
- Match latency: alarm_on, ringing and buzzy go high on the clk edge that samples the matching sec_tick, i.e. 1 cycle after the tick.
- Snooze and dismiss take effect on the next clk edge. ringing and buzzy drop in that same cycle.
- Ring duration: exactly RING_SECS sec_ticks after entry. missed is high for the one cycle following the edge that samples the RING_SECS-th tick.
- Snooze duration: exactly SNOOZE_SECS sec_ticks.
- Timers are wide enough for the parameter values. Both timers hold their value when sec_tick is low.
- A reset asserted mid-episode returns the block to IDLE on the next edge and clears all slots.

## Configuration

- ALARM_SNOOZE_LIMIT_EN defined: while snooze_cnt == MAX_SNOOZE, snooze is ignored in RING. The episode continues until dismiss, disarm or timeout.
- ALARM_SNOOZE_LIMIT_EN undefined: snooze is unlimited, and snooze_cnt saturates at 15.

## Test plan

- Program slot 2 at 07:30 armed, then drive 07:30:00 with sec_tick → alarm_on=1, ringing=1, buzzy=1 and active_idx=2 one cycle later.
- Ring with no input → missed pulses one cycle after the 60th sec_tick, then the block returns to IDLE with alarm_on=0.
- Snooze while ringing → snooze_cnt=1 and ringing=0; after 300 sec_ticks ringing=1 again; dismiss → IDLE.
- Arm slots 1 and 3 at the same time → active_idx=1. In the same cycle as snooze, write slot 1 with wr_arm=0 → IDLE with no missed pulse.
- Assert snooze and dismiss in the same cycle → IDLE. A match arriving during SNOOZE is ignored.
- With ALARM_SNOOZE_LIMIT_EN and MAX_SNOOZE=3, snooze 3 times; a 4th snooze leaves ringing=1 and snooze_cnt=3. Without the macro, the 4th snooze gives snooze_cnt=4.

Source files
------------

// File: rtl/alarm_bank.sv
// N-slot alarm compare with one ring/snooze episode FSM, ring auto-timeout and gated beep (build option ALARM_SNOOZE_LIMIT_EN caps snoozes at MAX_SNOOZE).
// Latency: outputs registered; match, snooze, dismiss and disarm all take effect on the next clk edge.
// Backpressure: none; sec_tick, snooze and dismiss are single-cycle pulses consumed when sampled.
module alarm_bank #(
    parameter int N_ALARMS    = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int BEEP_HALF   = 12000000,
    localparam int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick,
    input  logic [4:0]       cur_hour,
    input  logic [5:0]       cur_min,
    input  logic [5:0]       cur_sec,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [4:0]       wr_hour,
    input  logic [5:0]       wr_min,
    input  logic             wr_arm,
    input  logic             snooze,
    input  logic             dismiss,
    output logic             alarm_on,
    output logic             ringing,
    output logic             buzzy,
    output logic [IDX_W-1:0] active_idx,
    output logic [3:0]       snooze_cnt,
    output logic             missed
);

    localparam int RT_W = $clog2(RING_SECS + 1);
    localparam int ST_W = $clog2(SNOOZE_SECS + 1);
    localparam int BC_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t            state, state_nxt;
    logic [4:0]        slot_hour [N_ALARMS];
    logic [5:0]        slot_min  [N_ALARMS];
    logic [N_ALARMS-1:0] slot_arm;

    logic [RT_W-1:0]   ring_tmr, ring_tmr_nxt;
    logic [ST_W-1:0]   snz_tmr, snz_tmr_nxt;
    logic [BC_W-1:0]   beep_cnt, beep_cnt_nxt;
    logic              beep_phase, beep_phase_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [3:0]        cnt_nxt;
    logic              missed_nxt;
    logic              enter_ring;

    logic              match_any;
    logic [IDX_W-1:0]  match_idx;
    logic              disarm_act;
    logic              snooze_ok;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int k = N_ALARMS - 1; k >= 0; k--) begin
            if (sec_tick && slot_arm[k] && (cur_sec == 6'd0) &&
                (cur_hour == slot_hour[k]) && (cur_min == slot_min[k])) begin
                match_any = 1'b1;
                match_idx = IDX_W'(k);
            end
        end
    end

    assign disarm_act = wr_en && (wr_idx == active_idx) && !wr_arm;

`ifdef ALARM_SNOOZE_LIMIT_EN
    assign snooze_ok = snooze && (snooze_cnt != 4'(MAX_SNOOZE));
`else
    assign snooze_ok = snooze;
`endif

    always_comb begin
        state_nxt      = state;
        ring_tmr_nxt   = ring_tmr;
        snz_tmr_nxt    = snz_tmr;
        beep_cnt_nxt   = beep_cnt;
        beep_phase_nxt = beep_phase;
        idx_nxt        = active_idx;
        cnt_nxt        = snooze_cnt;
        missed_nxt     = 1'b0;
        enter_ring     = 1'b0;

        case (state)
            IDLE: begin
                if (match_any) begin
                    state_nxt  = RING;
                    idx_nxt    = match_idx;
                    cnt_nxt    = 4'd0;
                    enter_ring = 1'b1;
                end
            end
            RING: begin
                if (dismiss || disarm_act) begin
                    state_nxt = IDLE;
                end else if (snooze_ok) begin
                    state_nxt   = SNOOZE;
                    snz_tmr_nxt = ST_W'(SNOOZE_SECS);
                    if (snooze_cnt != 4'hF) begin
                        cnt_nxt = snooze_cnt + 4'd1;
                    end
                end else if (sec_tick) begin
                    if (ring_tmr <= RT_W'(1)) begin
                        state_nxt  = IDLE;
                        missed_nxt = 1'b1;
                    end else begin
                        ring_tmr_nxt = ring_tmr - RT_W'(1);
                    end
                end
            end
            SNOOZE: begin
                if (dismiss || disarm_act) begin
                    state_nxt = IDLE;
                end else if (sec_tick) begin
                    if (snz_tmr <= ST_W'(1)) begin
                        state_nxt  = RING;
                        enter_ring = 1'b1;
                    end else begin
                        snz_tmr_nxt = snz_tmr - ST_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Beep phase starts high on every ring entry and only advances while ringing continues.
        if (enter_ring) begin
            ring_tmr_nxt   = RT_W'(RING_SECS);
            beep_cnt_nxt   = '0;
            beep_phase_nxt = 1'b1;
        end else if ((state == RING) && (state_nxt == RING)) begin
            if (beep_cnt == BC_W'(BEEP_HALF - 1)) begin
                beep_cnt_nxt   = '0;
                beep_phase_nxt = !beep_phase;
            end else begin
                beep_cnt_nxt = beep_cnt + BC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ring_tmr   <= '0;
            snz_tmr    <= '0;
            beep_cnt   <= '0;
            beep_phase <= 1'b0;
            active_idx <= '0;
            snooze_cnt <= 4'd0;
            alarm_on   <= 1'b0;
            ringing    <= 1'b0;
            buzzy      <= 1'b0;
            missed     <= 1'b0;
            slot_arm   <= '0;
            for (int k = 0; k < N_ALARMS; k++) begin
                slot_hour[k] <= 5'd0;
                slot_min[k]  <= 6'd0;
            end
        end else begin
            state      <= state_nxt;
            ring_tmr   <= ring_tmr_nxt;
            snz_tmr    <= snz_tmr_nxt;
            beep_cnt   <= beep_cnt_nxt;
            beep_phase <= beep_phase_nxt;
            active_idx <= idx_nxt;
            snooze_cnt <= cnt_nxt;
            alarm_on   <= (state_nxt != IDLE);
            ringing    <= (state_nxt == RING);
            buzzy      <= (state_nxt == RING) && beep_phase_nxt;
            missed     <= missed_nxt;
            if (wr_en && (int'(wr_idx) < N_ALARMS)) begin
                slot_hour[wr_idx] <= wr_hour;
                slot_min[wr_idx]  <= wr_min;
                slot_arm[wr_idx]  <= wr_arm;
            end
        end
    end

endmodule
